decoder_3x8: RTL and testbench
==============================

Name: decoder_3x8

Overview:
- Binary-to-one-hot decoder: 3-bit select s drives exactly one of 8 output lines.
- Primary output Y is purely combinational, so it follows s with zero cycles of latency and needs no clock.
- A registered copy of the decode, with a valid flag and a select-change flag, is provided for synchronous consumers in the SPARC datapath, such as register-file write-enable and window select.
- Single clock domain; asynchronous active-low reset.

Parameters:
- ACTIVE_LOW_OUT, 0: when 1, both Y and Y_q are bitwise inverted (one-cold). Default is one-hot.
- RESET_SEL, 3'b000: value loaded into s_q on reset. It is not reflected in Y_q; Y_q resets to all-inactive.

Ports:
- clk  input  1  rising-edge clock, used only by the registered outputs.
- rst_n  input  1  asynchronous active-low reset, used only by the registered outputs.
- Y  output  8  combinational decode of s.
- s  input  3  binary select.
- en  input  1  capture enable for the registered path.
- Y_q  output  8  registered decode.
- s_q  output  3  registered select.
- valid_q  output  1  high once at least one capture has occurred since reset.
- chg_q  output  1  high for one cycle after a capture whose select differs from the previous s_q.
- Declaration order is fixed: Y, s, clk, rst_n, en, Y_q, s_q, valid_q, chg_q. Positional instantiation as (Y, s) must work with the remaining ports left unconnected.

Behaviour:
- Combinational path:
  - Y[i] = 1 exactly when s == i, for i = 0..7; all other bits are 0.
  - Y depends only on s. It is independent of clk, rst_n and en, and stays correct while those are unconnected or X.
  - s containing X or Z drives Y to all X; no false one-hot value may be produced.
  - With ACTIVE_LOW_OUT=1, Y = ~onehot(s).
  - There is no illegal select value: all 8 codes are valid, and exactly one bit of Y is active at any time.
- Registered path:
  - Asynchronous reset (rst_n = 0): Y_q = 8'h00 (8'hFF if ACTIVE_LOW_OUT), s_q = RESET_SEL, valid_q = 0, chg_q = 0. These values are held while rst_n is low.
  - Reset deassertion is synchronized by the consumer. The block has no internal reset synchronizer.
  - Rising clk edge with en = 1:
    - s_q <= s
    - Y_q <= decode(s)
    - valid_q <= 1
    - chg_q <= valid_q && (s != s_q)
  - The first capture after reset never flags a change.
  - Rising clk edge with en = 0: Y_q, s_q and valid_q hold; chg_q <= 0.
  - Latency: Y_q reflects s one cycle after the capturing edge.
  - Reset asserted mid-operation overrides any capture in the same cycle. The registered outputs go to reset values immediately, with no clock edge required.
  - Wrap-around: stepping s from 3'b111 to 3'b000 is an ordinary change. Y moves from bit 7 to bit 0, and chg_q pulses if the step is captured.
  - Invariant: whenever valid_q = 1, Y_q is one-hot (one-cold if ACTIVE_LOW_OUT) and Y_q == decode(s_q).

Test Plan:
- Exhaustive combinational sweep, clk/rst_n/en unconnected: s = 000 then +1 every 10 time units through 111. Y must read 00000001, 00000010, 00000100, 00001000, 00010000, 00100000, 01000000, 10000000, each in the same timestep as the s change.
- Wrap-around: s 111 -> 000. Y changes 10000000 -> 00000001 with no intermediate multi-hot value.
- Reset and capture:
  - Hold rst_n = 0: Y_q = 00, s_q = 000, valid_q = 0, chg_q = 0.
  - Release reset, s = 101, en = 1, one edge: Y_q = 8'h20, valid_q = 1, chg_q = 0.
  - Then s = 010 with one edge: Y_q = 8'h04, chg_q = 1 for exactly one cycle.
- Enable hold: en = 0 while s toggles 011 -> 110 over 3 edges. Y tracks s, while Y_q and s_q stay at their prior values and chg_q = 0.
- Async reset mid-stream: assert rst_n = 0 between clock edges with valid_q = 1. Y_q = 00 and valid_q = 0 immediately; Y still equals decode(s).
- ACTIVE_LOW_OUT = 1 build: s = 011 gives Y = 11110111; Y_q after reset = 8'hFF.

Source files
------------

// File: rtl/decoder_3x8.sv
// 3-to-8 binary decoder with a combinational output and an
// optional registered copy (select, valid and change flags).
module decoder_3x8 #(
  parameter bit       ACTIVE_LOW_OUT = 1'b0,
  parameter bit [2:0] RESET_SEL      = 3'b000
) (
  output logic [7:0] Y,
  input  logic [2:0] s,
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] Y_q,
  output logic [2:0] s_q,
  output logic       valid_q,
  output logic       chg_q
);

  localparam logic [7:0] IDLE =
    ACTIVE_LOW_OUT ? 8'hFF : 8'h00;

  logic [7:0] onehot;
  logic [7:0] dec;
  logic [7:0] Y_d;
  logic [2:0] s_d;
  logic       valid_d;
  logic       chg_d;

  // Shift by an unknown amount yields all-X, never a false one-hot.
  assign onehot = 8'd1 << s;
  assign dec    = ACTIVE_LOW_OUT ? ~onehot : onehot;
  assign Y      = dec;

  always_comb begin
    Y_d     = Y_q;
    s_d     = s_q;
    valid_d = valid_q;
    chg_d   = 1'b0;
    if (en) begin
      Y_d     = dec;
      s_d     = s;
      valid_d = 1'b1;
      chg_d   = valid_q && (s != s_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y_q     <= IDLE;
      s_q     <= RESET_SEL;
      valid_q <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      Y_q     <= Y_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      chg_q   <= chg_d;
    end
  end

endmodule

// File: tb/tb_decoder_3x8.sv
// Directed bench for decoder_3x8: combinational sweep,
// capture/enable/change behaviour, async reset, one-cold build.
module tb_decoder_3x8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] s;
  logic [2:0] s2;
  logic [7:0] Y, Y_q, Y2, Y2_q;
  logic [2:0] s_q, s2_q;
  logic       valid_q, chg_q, valid2_q, chg2_q;

  int total = 0;
  int bad   = 0;

  logic [7:0] oh_tab [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                             8'h10, 8'h20, 8'h40, 8'h80};

  always #5 clk = ~clk;

  decoder_3x8 u_dut (
    .Y(Y), .s(s), .clk(clk), .rst_n(rst_n), .en(en),
    .Y_q(Y_q), .s_q(s_q), .valid_q(valid_q), .chg_q(chg_q)
  );

  decoder_3x8 #(.ACTIVE_LOW_OUT(1'b1)) u_dut_lo (
    .Y(Y2), .s(s2), .clk(clk), .rst_n(rst_n), .en(en),
    .Y_q(Y2_q), .s_q(s2_q), .valid_q(valid2_q),
    .chg_q(chg2_q)
  );

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cap_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    s     = 3'd0;
    s2    = 3'd0;

    // combinational sweep, reset held, no capture
    for (int i = 0; i < 8; i++) begin
      s = 3'(i);
      #0;
      chk($sformatf("sweep_same_step%0d", i), Y, oh_tab[i]);
      #10;
      chk($sformatf("sweep%0d", i), Y, oh_tab[i]);
    end
    s = 3'd7; #1;
    chk("wrap_pre", Y, 8'h80);
    s = 3'd0; #1;
    chk("wrap_post", Y, 8'h01);

    chk("rst_Yq", Y_q, 8'h00);
    chk("rst_sq", {5'd0, s_q}, 8'h00);
    chk("rst_valid", {7'd0, valid_q}, 8'h00);
    chk("rst_chg", {7'd0, chg_q}, 8'h00);

    s2 = 3'd3; #1;
    chk("lo_Y", Y2, 8'hF7);
    chk("lo_rst_Yq", Y2_q, 8'hFF);

    // release reset, first capture
    @(negedge clk);
    rst_n = 1'b1;
    s = 3'b101;
    en = 1'b1;
    cap_edge();
    chk("cap1_Yq", Y_q, 8'h20);
    chk("cap1_sq", {5'd0, s_q}, 8'h05);
    chk("cap1_valid", {7'd0, valid_q}, 8'h01);
    chk("cap1_chg", {7'd0, chg_q}, 8'h00);
    chk("lo_cap_Yq", Y2_q, 8'hF7);

    @(negedge clk);
    s = 3'b010;
    cap_edge();
    chk("cap2_Yq", Y_q, 8'h04);
    chk("cap2_chg", {7'd0, chg_q}, 8'h01);

    // enable hold while s toggles
    @(negedge clk);
    en = 1'b0;
    s = 3'b011;
    cap_edge();
    chk("hold0_chg", {7'd0, chg_q}, 8'h00);
    chk("hold0_Y", Y, 8'h08);
    chk("hold0_Yq", Y_q, 8'h04);
    @(negedge clk);
    s = 3'b110;
    cap_edge();
    chk("hold1_Y", Y, 8'h40);
    chk("hold1_Yq", Y_q, 8'h04);
    chk("hold1_sq", {5'd0, s_q}, 8'h02);
    @(negedge clk);
    s = 3'b011;
    cap_edge();
    chk("hold2_Yq", Y_q, 8'h04);
    chk("hold2_chg", {7'd0, chg_q}, 8'h00);

    // wrap-around through the registered path
    @(negedge clk);
    en = 1'b1;
    s = 3'b111;
    cap_edge();
    chk("cap7_Yq", Y_q, 8'h80);
    chk("cap7_chg", {7'd0, chg_q}, 8'h01);
    @(negedge clk);
    s = 3'b000;
    cap_edge();
    chk("wrapq_Yq", Y_q, 8'h01);
    chk("wrapq_chg", {7'd0, chg_q}, 8'h01);
    @(negedge clk);
    cap_edge();
    chk("same_chg", {7'd0, chg_q}, 8'h00);
    chk("same_valid", {7'd0, valid_q}, 8'h01);

    // async reset between edges
    s = 3'b100;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_Yq", Y_q, 8'h00);
    chk("arst_valid", {7'd0, valid_q}, 8'h00);
    chk("arst_Y", Y, 8'h10);
    chk("arst_lo_Yq", Y2_q, 8'hFF);
    cap_edge();
    chk("arst_hold_Yq", Y_q, 8'h00);
    chk("arst_hold_sq", {5'd0, s_q}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
